// File: rtl/irq_defs.sv
// Shared constants for the memory-mapped interrupt controller:
// register offsets, ACTIVE layout and FSM state encoding.
package irq_defs;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_ACT  = 2'd2;
  localparam logic [1:0] OFF_EOI  = 2'd3;

  localparam int ACT_BIT = 31;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting index at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   gnt_o,
  output logic         any_o
);

  logic [N-1:0] rot;
  int           ofs;
  int           sum;

  // rotate so ptr_i sits at bit 0, then take the lowest set bit
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    ofs = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) ofs = k;
    end
    sum = int'(ptr_i) + ofs;
    if (sum >= N) sum = sum - N;
    gnt_o = 3'(sum);
    any_o = |req_i;
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with PENDING/MASK/ACTIVE/EOI
// registers and a round-robin IDLE/REQ/SERVICE handshake to CP0.
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               TakenInterrupt,
  output logic               IrqAddress,
  output logic [31:0]        rd_data,
  output logic               InterruptOut
);

  import irq_defs::*;

  logic [NUM_SRC-1:0] prev_q, pend_q, mask_q;
  logic [NUM_SRC-1:0] pend_d, mask_d;
  logic [NUM_SRC-1:0] edge_w, w1c, sw_pend;
  logic [NUM_SRC-1:0] cur_oh, take_clr;
  state_e             state_q;
  logic [ID_W-1:0]    rr_q, cur_q, nxt_rr;
  logic [ID_W-1:0]    gnt;
  logic               act_q, irq_q, any;
  logic               wr, eoi, cur_hit;
  logic [1:0]         off;
  logic               unused_bits;

  assign IrqAddress   = (address[31:4] == BASE_ADDR[31:4]);
  assign wr           = MemWrite & IrqAddress;
  assign off          = address[3:2];
  assign eoi          = wr && (off == OFF_EOI);
  assign edge_w       = irq_src & ~prev_q;
  assign cur_oh       = NUM_SRC'(1) << cur_q;
  assign InterruptOut = irq_q;
  assign nxt_rr       = (cur_q == ID_W'(NUM_SRC - 1)) ? '0 : cur_q + 1'b1;
  assign unused_bits  = ^{address[1:0], data[31:NUM_SRC]};

  // software view of PENDING/MASK after this cycle's store, and take-clear
  always_comb begin
    w1c = '0;
    if (wr && (off == OFF_PEND)) w1c = data[NUM_SRC-1:0];
    mask_d = mask_q;
    if (wr && (off == OFF_MASK)) mask_d = data[NUM_SRC-1:0];
    sw_pend  = (pend_q & ~w1c) | edge_w;
    cur_hit  = |(sw_pend & mask_d & cur_oh);
    take_clr = '0;
    if (state_q == S_REQ && cur_hit && TakenInterrupt) take_clr = cur_oh;
    pend_d = (sw_pend & ~take_clr) | edge_w;
  end

  // combinational register read port
  always_comb begin
    rd_data = '0;
    if (MemRead && IrqAddress) begin
      unique case (1'b1)
        (off == OFF_PEND): rd_data = 32'(pend_q);
        (off == OFF_MASK): rd_data = 32'(mask_q);
        (off == OFF_ACT): begin
          rd_data[ACT_BIT]  = act_q;
          rd_data[ID_W-1:0] = cur_q;
        end
        (off == OFF_EOI):  rd_data = '0;
      endcase
    end
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req_i (pend_q & mask_q),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .any_o (any)
  );

  // edge detect and software-visible registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      prev_q <= irq_src;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // request/service handshake with registered InterruptOut
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      cur_q   <= '0;
      act_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any) begin
            state_q <= S_REQ;
            cur_q   <= gnt;
            irq_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (!cur_hit) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end else if (TakenInterrupt) begin
            state_q <= S_SVC;
            act_q   <= 1'b1;
            irq_q   <= 1'b0;
          end
        end
        S_SVC: begin
          if (eoi) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            rr_q    <= nxt_rr;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios plus
// random traffic checked against a rule-level reference model.
module tb_irq_controller;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'hffff0080;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_MASK = BASE + 32'd4;
  localparam logic [31:0] A_ACT  = BASE + 32'd8;
  localparam logic [31:0] A_EOI  = BASE + 32'd12;
  localparam int unsigned NM = (1 << N) - 1;
  localparam int ST_IDLE = 0;
  localparam int ST_REQ  = 1;
  localparam int ST_SVC  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   dat = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic          tk = 1'b0;
  logic          irq_addr;
  logic [31:0]   rdata;
  logic          irq_out;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .irq_src        (src),
    .address        (addr),
    .data           (dat),
    .MemRead        (rd),
    .MemWrite       (wr),
    .TakenInterrupt (tk),
    .IrqAddress     (irq_addr),
    .rd_data        (rdata),
    .InterruptOut   (irq_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        ia;
  } rd_exp_t;

  rd_exp_t rdq[$];
  bit      irqq[$];

  int unsigned m_pend, m_mask, m_prev, m_cur, m_rr;
  bit          m_act;
  int          m_st;

  function void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  function void model_reset();
    m_pend = 0;
    m_mask = 0;
    m_prev = 0;
    m_cur  = 0;
    m_rr   = 0;
    m_act  = 0;
    m_st   = ST_IDLE;
  endfunction

  function rd_exp_t exp_read();
    rd_exp_t r;
    bit      inwin;
    int      w;
    inwin = (addr[31:4] == BASE[31:4]);
    w = int'(addr[3:2]);
    r.ia = inwin;
    r.rd = 32'd0;
    if (rd && inwin) begin
      case (w)
        0: r.rd = m_pend;
        1: r.rd = m_mask;
        2: r.rd = (32'(m_act) << 31) | m_cur;
        default: r.rd = 32'd0;
      endcase
    end
    return r;
  endfunction

  // what the controller does at the coming clock edge
  function void model_advance();
    bit          inwin, found;
    int          w, idx;
    int unsigned edges, p, mk, oh, ready;
    inwin = (addr[31:4] == BASE[31:4]);
    w = int'(addr[3:2]);
    edges = 32'(src) & ~m_prev & NM;
    p = m_pend;
    mk = m_mask;
    if (wr && inwin && w == 0) p = p & ~(dat & NM);
    if (wr && inwin && w == 1) mk = dat & NM;
    p = p | edges;
    case (m_st)
      ST_IDLE: begin
        ready = m_pend & m_mask;
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (int'(m_rr) + k) % N;
          if (!found && ((ready >> idx) & 1) == 1) begin
            found = 1;
            m_cur = idx;
            m_st  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        oh = 1 << m_cur;
        if ((p & mk & oh) == 0) m_st = ST_IDLE;
        else if (tk) begin
          m_st  = ST_SVC;
          m_act = 1;
          if ((edges & oh) == 0) p = p & ~oh;
        end
      end
      default: begin
        if (wr && inwin && w == 3) begin
          m_st  = ST_IDLE;
          m_act = 0;
          m_rr  = (m_cur + 1) % N;
        end
      end
    endcase
    m_pend = p;
    m_mask = mk;
    m_prev = 32'(src) & NM;
  endfunction

  // monitor: pop expectations while the cycle's outputs are stable
  always @(negedge clk) begin
    if (rst_n) begin
      if (irqq.size() > 0) begin
        bit e;
        e = irqq.pop_front();
        chk("irq_out", 32'(irq_out), 32'(e));
      end
      if (rdq.size() > 0) begin
        rd_exp_t r;
        r = rdq.pop_front();
        chk("rd_data", rdata, r.rd);
        chk("irq_addr", 32'(irq_addr), 32'(r.ia));
      end
    end
  end

  task automatic step(input logic [N-1:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic r,
                      input logic w, input logic t);
    @(posedge clk);
    #1;
    src  = s;
    addr = a;
    dat  = d;
    rd   = r;
    wr   = w;
    tk   = t;
    irqq.push_back(m_st == ST_REQ);
    rdq.push_back(exp_read());
    model_advance();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    src   = 4'b0010;
    addr  = A_ACT;
    dat   = '0;
    rd    = 1'b1;
    wr    = 1'b0;
    tk    = 1'b0;
    #1;
    chk("rst_irq_out", 32'(irq_out), 32'd0);
    chk("rst_active", rdata, 32'd0);
    model_reset();
    #20;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    rd    = 1'b0;
    addr  = '0;
    model_advance();
  endtask

  initial begin
    logic [N-1:0] s;
    logic [31:0]  a, d;
    logic         r, w, t;

    model_reset();
    addr = A_ACT;
    rd   = 1'b1;
    #1;
    chk("reset_irq_out", 32'(irq_out), 32'd0);
    chk("reset_active", rdata, 32'd0);
    rd   = 1'b0;
    addr = '0;
    #1;
    rst_n = 1'b1;
    model_advance();

    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("reset_pend", rdata, 32'd0);
    step(0, A_MASK, 0, 1, 0, 0);
    #1 chk("reset_mask", rdata, 32'd0);

    // single source: pend, request two edges later, take
    step(0, A_MASK, 32'h1, 0, 1, 0);
    step(4'b0001, A_PEND, 0, 1, 0, 0);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("s0_pend", rdata, 32'h1);
    chk("s0_irq_lo", 32'(irq_out), 32'd0);
    step(0, A_ACT, 0, 1, 0, 1);
    #1 chk("s0_irq_hi", 32'(irq_out), 32'd1);
    step(0, A_ACT, 0, 1, 0, 0);
    #1 chk("s0_active", rdata, 32'h80000000);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("s0_pend_clr", rdata, 32'h0);
    step(0, A_EOI, 32'hdead, 0, 1, 0);

    // simultaneous edges on 1 and 3: round-robin order
    step(0, A_MASK, 32'hF, 0, 1, 0);
    step(4'b1010, 0, 0, 0, 0, 0);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("rr_pend", rdata, 32'hA);
    step(0, A_ACT, 0, 1, 0, 1);
    step(0, A_ACT, 0, 1, 0, 0);
    #1 chk("rr_first", rdata, 32'h80000001);
    step(0, A_EOI, 0, 0, 1, 0);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("rr_pend_left", rdata, 32'h8);
    step(0, A_ACT, 0, 1, 0, 1);
    step(0, A_ACT, 0, 1, 0, 0);
    #1 chk("rr_second", rdata, 32'h80000003);
    step(0, A_EOI, 0, 0, 1, 0);

    // mask out while requesting
    step(4'b0100, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, A_MASK, 32'h0, 0, 1, 0);
    #1 chk("mask_req_hi", 32'(irq_out), 32'd1);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("mask_req_lo", 32'(irq_out), 32'd0);
    chk("mask_pend_kept", rdata, 32'h4);

    // set wins over write-1-to-clear
    step(4'b0001, A_PEND, 32'h1, 0, 1, 0);
    step(0, A_PEND, 0, 1, 0, 0);
    #1 chk("set_wins", rdata, 32'h5);
    step(0, A_PEND, 32'h5, 0, 1, 0);

    // decode boundaries and strobe gating
    step(0, BASE + 32'd16, 0, 1, 0, 0);
    #1 chk("out_win_ia", 32'(irq_addr), 32'd0);
    chk("out_win_rd", rdata, 32'd0);
    step(0, A_MASK, 32'hF, 0, 0, 0);
    step(0, A_MASK, 0, 1, 0, 0);
    #1 chk("no_strobe_mask", rdata, 32'd0);

    // reset during service, source held high across release
    step(0, A_MASK, 32'h1, 0, 1, 0);
    step(4'b0001, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, A_ACT, 0, 1, 0, 0);
    #1 chk("svc_active", rdata, 32'h80000000);
    reset_mid();
    step(4'b0010, A_PEND, 0, 1, 0, 0);
    #1 chk("rel_edge", rdata, 32'h2);
    step(4'b0010, A_ACT, 0, 1, 0, 0);
    #1 chk("rel_active", rdata, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s = '0;
      for (int b = 0; b < N; b++) s[b] = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: a = $urandom;
        1: a = BASE + 32'd16;
        default: a = BASE + 32'($urandom_range(0, 3) * 4)
                     + 32'($urandom_range(0, 3));
      endcase
      d = $urandom;
      r = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 2) == 0);
      if (m_st == ST_SVC && $urandom_range(0, 3) == 0) begin
        a = A_EOI;
        w = 1'b1;
      end
      step(s, a, d, r, w, t);
      if (i == 200) reset_mid();
    end

    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of interrupt sources (legal range 1..8).
REQ-002 Parameter BASE_ADDR, default 32'hffff0080, SHALL set the word-aligned base of the 16-byte register window.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 irq_src  input  NUM_SRC  SHALL carry raw interrupt requests, rising-edge sensitive.
REQ-006 address  input  32  SHALL carry the CPU data address (ALU output).
REQ-007 data  input  32  SHALL carry the CPU store data.
REQ-008 MemRead, MemWrite  input  1 each  SHALL carry the CPU load/store strobes.
REQ-009 TakenInterrupt  input  1  SHALL carry the CP0 interrupt-taken indication.
REQ-010 IrqAddress  output  1  SHALL be high when address[31:4] equals BASE_ADDR[31:4], so the top level gates data memory off.
REQ-011 rd_data  output  32  SHALL carry register read data; zero when not (MemRead & IrqAddress).
REQ-012 InterruptOut  output  1  SHALL be the registered interrupt request to CP0.

Function
REQ-013 Register map (offset from BASE_ADDR) SHALL be: 0x0 PENDING (R, write-1-to-clear), 0x4 MASK (R/W), 0x8 ACTIVE (R: bit 31 = in service, bits 2:0 = source id), 0xC EOI (W, data ignored); bits above NUM_SRC read 0.
REQ-014 Reads SHALL be combinational; writes SHALL take effect at the clk edge where MemWrite & IrqAddress is high.
REQ-015 Each source SHALL be sampled into a prev register; a cycle with irq_src[i]=1 and prev[i]=0 SHALL set PENDING[i] at that edge.
REQ-016 Set SHALL win over a simultaneous write-1-to-clear of the same bit.
REQ-017 FSM states SHALL be IDLE, REQ, SERVICE; InterruptOut = (state==REQ).
REQ-018 IDLE -> REQ when (PENDING & MASK) != 0; the winner SHALL be chosen round-robin starting at pointer rr_ptr and latched as cur_id.
REQ-019 REQ -> SERVICE on TakenInterrupt; at that edge PENDING[cur_id] SHALL be cleared and ACTIVE set.
REQ-020 REQ -> IDLE if PENDING[cur_id] & MASK[cur_id] becomes 0 before TakenInterrupt (masked or cleared by software).
REQ-021 SERVICE -> IDLE on an EOI write; rr_ptr SHALL become (cur_id+1) mod NUM_SRC and ACTIVE bit 31 SHALL clear.
REQ-022 EOI writes in IDLE or REQ SHALL be ignored; new edges during SERVICE SHALL latch in PENDING without preemption.
REQ-023 Latency: a rising edge sampled at edge k with mask set and FSM idle SHALL drive InterruptOut high after edge k+1.

Reset
REQ-024 Asserting reset (low) SHALL immediately force PENDING=0, MASK=0, prev=0, state=IDLE, rr_ptr=0, cur_id=0, InterruptOut=0, regardless of an in-progress service.
REQ-025 A source already high at reset release SHALL register as an edge on the first clock.

Structure
REQ-026 Register offsets, FSM state encodings and ACTIVE bit positions SHALL live in a shared constants include (irq_defs).
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, rr_ptr; outputs grant id, any).

Verification
REQ-028 MASK=4'b0001, pulse irq_src[0] -> PENDING=1, InterruptOut high two edges later; TakenInterrupt -> ACTIVE=0x80000000, PENDING=0.
REQ-029 MASK=4'b1111, edges on src 1 and 3 same cycle, rr_ptr=0 -> src 1 served; EOI -> src 3 served next, ACTIVE=0x80000003.
REQ-030 In REQ for src 2, write MASK=0 -> InterruptOut drops next cycle, state IDLE, PENDING[2] still 1.
REQ-031 Edge on src 0 coincident with write PENDING=0x1 -> PENDING[0] reads 1.
REQ-032 Reset asserted mid-SERVICE -> all outputs 0 asynchronously; read of 0xffff0088 returns 0 after release.
REQ-033 Load from 0xffff0090 -> IrqAddress=0, rd_data=0; store to 0xffff0084 -> MASK unchanged when MemWrite=0.
